// File: rtl/apb_cmd_sequencer.sv
// APB command sequencer: buffers commands in a FIFO and issues them one at a time as APB transfers.
// Optional ACCESS-phase timeout abort is compiled in when APB_SEQ_TIMEOUT_EN is defined.
module apb_cmd_sequencer #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int TO_CYC = 16
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [AW-1:0] m_paddr,
  output logic [DW-1:0] m_pwdata,
  input  logic          m_pready,
  input  logic          m_pslverr,
  input  logic [DW-1:0] m_prdata,
  output logic          busy,
  output logic          to_evt
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t      state;
  cmd_t        mem [DEPTH];
  cmd_t        head;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        issue;
  logic        to_hit;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr[PW-1:0]];
  assign issue     = (state == IDLE) && !empty && (!rsp_valid || rsp_ready);
  assign pop       = (state == ACCESS) && (m_pready || to_hit);
  assign busy      = !empty || (state != IDLE);

  // NOTE: the payload array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= cmd_t'{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  logic [CW-1:0] to_cnt;

  // The counter holds k-1 during the k-th ACCESS cycle, so the TO_CYC-th stalled cycle aborts.
  assign to_hit = !m_pready && (to_cnt == CW'(TO_CYC - 1));
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = 32'(TO_CYC);
  assign to_hit        = 1'b0;
  assign to_evt        = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_SEQ_TIMEOUT_EN
      to_cnt    <= '0;
      to_evt    <= 1'b0;
`endif
    end else begin
`ifdef APB_SEQ_TIMEOUT_EN
      to_evt <= 1'b0;
`endif
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (issue) begin
            state    <= SETUP;
            m_psel   <= 1'b1;
            m_pwrite <= head.write;
            m_paddr  <= head.addr;
            m_pwdata <= head.wdata;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          m_penable <= 1'b1;
`ifdef APB_SEQ_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (m_pready) begin
            state     <= IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= m_pslverr;
            rsp_rdata <= m_pwrite ? '0 : m_prdata;
          end
`ifdef APB_SEQ_TIMEOUT_EN
          else if (to_hit) begin
            state     <= IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            to_evt    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Scoreboard bench for apb_cmd_sequencer: expected APB requests and responses are queued at push
// time and compared by monitors as the DUT issues SETUP phases and hands off responses.
module tb_apb_cmd_sequencer;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  logic        pclk;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pready;
  logic        m_pslverr;
  logic [31:0] m_prdata;
  logic        busy;
  logic        to_evt;

  int   n_cmp = 0;
  int   n_err = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  apb_cmd_sequencer #(.AW(32), .DW(32), .DEPTH(4), .TO_CYC(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .busy(busy), .to_evt(to_evt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Request monitor: each transfer has exactly one SETUP cycle.
  always @(negedge pclk) begin
    req_t e;
    if (preset_n && m_psel && !m_penable) begin
      n_cmp++;
      if (exp_req_q.size() == 0) begin
        n_err++;
        $display("FAIL apb_req: unexpected SETUP addr=%h", m_paddr);
      end else begin
        e = exp_req_q.pop_front();
        if ({m_pwrite, m_paddr, m_pwdata} !== {e.w, e.a, e.d}) begin
          n_err++;
          $display("FAIL apb_req: got w=%b a=%h d=%h, want w=%b a=%h d=%h",
                   m_pwrite, m_paddr, m_pwdata, e.w, e.a, e.d);
        end
      end
    end
  end

  // Response monitor: valid and ready both high here means a handshake at the next edge.
  always @(negedge pclk) begin
    rsp_t e;
    if (preset_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (exp_rsp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp: unexpected response rdata=%h err=%b", rsp_rdata, rsp_err);
      end else begin
        e = exp_rsp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== {e.rd, e.err}) begin
          n_err++;
          $display("FAIL rsp: got rdata=%h err=%b, want rdata=%h err=%b",
                   rsp_rdata, rsp_err, e.rd, e.err);
        end
      end
    end
  end

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] erd, input logic eerr);
    int t;
    t = 0;
    exp_req_q.push_back('{w, a, d});
    exp_rsp_q.push_back('{erd, eerr});
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && t < 200) begin @(posedge pclk); #1; t++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: cmd_ready=%b, want 1 within 200 cycles", cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
  endtask

  // Zero or more wait cycles in ACCESS, then one ready cycle with the given response.
  task automatic serve(input int waits, input logic [31:0] rd, input logic err);
    int t;
    t = 0;
    while (!(m_psel && m_penable) && t < 50) begin @(posedge pclk); #1; t++; end
    if (!(m_psel && m_penable)) begin
      n_cmp++; n_err++;
      $display("FAIL serve_timeout: ACCESS not reached, psel=%b penable=%b, want 1/1", m_psel, m_penable);
      return;
    end
    repeat (waits) begin @(posedge pclk); #1; end
    m_pready = 1'b1; m_prdata = rd; m_pslverr = err;
    @(posedge pclk); #1;
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
  endtask

  task automatic test_reset();
    logic [103:0] act;
    preset_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; m_pready = 0; m_pslverr = 0; m_prdata = 0;
    #1;
    act = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, rsp_valid, rsp_rdata,
           rsp_err, to_evt, busy, cmd_ready};
    n_cmp++;
    if (act !== {3'b000, 64'h0, 1'b0, 32'h0, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_values: got %h, want %h", act, {3'b000, 64'h0, 1'b0, 32'h0, 3'b000, 1'b1});
    end
    @(negedge pclk); @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_latency();
    m_pready = 1'b1; m_prdata = 32'h1234_5678; rsp_ready = 1'b1;
    exp_req_q.push_back('{1'b1, 32'h10, 32'hA5A5_A5A5});
    exp_rsp_q.push_back('{32'h0, 1'b0});
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_A5A5;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (m_psel !== 1'b0) begin n_err++; $display("FAIL lat_n0: psel=%b, want 0", m_psel); end
    @(posedge pclk); #1;
    n_cmp++;
    if ({m_psel, m_penable} !== 2'b10) begin
      n_err++; $display("FAIL lat_n1: psel/penable=%b, want 10", {m_psel, m_penable});
    end
    @(posedge pclk); #1;
    n_cmp++;
    if ({m_psel, m_penable, rsp_valid} !== 3'b110) begin
      n_err++; $display("FAIL lat_n2: psel/penable/rsp_valid=%b, want 110", {m_psel, m_penable, rsp_valid});
    end
    @(posedge pclk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, m_psel} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL lat_n3: valid=%b err=%b rdata=%h psel=%b, want 1 0 00000000 0",
               rsp_valid, rsp_err, rsp_rdata, m_psel);
    end
    m_pready = 1'b0; m_prdata = '0;
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    logic        wr    [5];
    int t;
    addrs = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    wr    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    m_pready = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      push_cmd(wr[i], addrs[i], addrs[i] + 32'h100, wr[i] ? 32'h0 : ~addrs[i], 1'b0);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_after_4: cmd_ready=%b, want 0", cmd_ready); end
    fork
      begin
        exp_req_q.push_back('{wr[4], addrs[4], addrs[4] + 32'h100});
        exp_rsp_q.push_back('{~addrs[4], 1'b0});
        cmd_valid = 1'b1; cmd_write = wr[4]; cmd_addr = addrs[4]; cmd_wdata = addrs[4] + 32'h100;
        t = 0;
        while (!cmd_ready && t < 200) begin @(posedge pclk); #1; t++; end
        n_cmp++;
        if ({cmd_ready, rsp_valid} !== 2'b11) begin
          n_err++;
          $display("FAIL fifth_accept: cmd_ready=%b rsp_valid=%b, want 1 1 (space only at first completion)",
                   cmd_ready, rsp_valid);
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) serve((i == 0) ? 3 : 1, ~addrs[i], 1'b0);
      end
    join
    repeat (2) begin @(posedge pclk); #1; end
  endtask

  task automatic test_err_hold();
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b1);
    push_cmd(1'b1, 32'h24, 32'h77, 32'h0, 1'b0);
    serve(3, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_err, m_psel} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL err_hold[%0d]: valid=%b rdata=%h err=%b psel=%b, want 1 deadbeef 1 0",
                 i, rsp_valid, rsp_rdata, rsp_err, m_psel);
      end
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    serve(0, 32'hCAFE_F00D, 1'b0);
    @(posedge pclk); #1;
  endtask

`ifdef APB_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    int t;
    rsp_ready = 1'b1; m_pready = 1'b0; m_prdata = 32'hFFFF_FFFF;
    push_cmd(1'b0, 32'h30, 32'h0, 32'h0, 1'b1);
    push_cmd(1'b1, 32'h34, 32'h99, 32'h0, 1'b0);
    t = 0;
    while (!m_penable && t < 20) begin @(posedge pclk); #1; t++; end
    cnt = 0;
    while (m_penable && cnt < 100) begin
      cnt++;
      @(posedge pclk); #1;
    end
    n_cmp++;
    if (cnt !== 16) begin n_err++; $display("FAIL to_cycles: got %0d ACCESS cycles, want 16", cnt); end
    n_cmp++;
    if ({to_evt, rsp_valid, rsp_err, rsp_rdata} !== {3'b111, 32'h0}) begin
      n_err++;
      $display("FAIL to_abort: to_evt=%b valid=%b err=%b rdata=%h, want 1 1 1 00000000",
               to_evt, rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge pclk); #1;
    n_cmp++;
    if (to_evt !== 1'b0) begin n_err++; $display("FAIL to_pulse: to_evt=%b, want 0", to_evt); end
    m_prdata = '0;
    serve(0, 32'h0, 1'b0);
    @(posedge pclk); #1;
  endtask
`else
  task automatic test_no_timeout();
    logic saw_to;
    logic left_access;
    int t;
    saw_to = 1'b0; left_access = 1'b0;
    rsp_ready = 1'b1; m_pready = 1'b0;
    push_cmd(1'b0, 32'h60, 32'h0, 32'h600D_F00D, 1'b0);
    t = 0;
    while (!m_penable && t < 20) begin @(posedge pclk); #1; t++; end
    repeat (40) begin
      @(posedge pclk); #1;
      if (to_evt) saw_to = 1'b1;
      if (!m_penable) left_access = 1'b1;
    end
    n_cmp++;
    if ({saw_to, left_access} !== 2'b00) begin
      n_err++; $display("FAIL no_timeout: to_evt seen=%b left ACCESS=%b, want 0 0", saw_to, left_access);
    end
    serve(0, 32'h600D_F00D, 1'b0);
    @(posedge pclk); #1;
  endtask
`endif

  task automatic test_reset_mid();
    logic [103:0] act;
    logic saw_rsp;
    logic saw_sel;
    logic saw_busy;
    rsp_ready = 1'b1; m_pready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h70 + 32'(4 * i), 32'h5555_0000 + 32'(i), 32'h0, 1'b0);
    n_cmp++;
    if ({m_penable, busy} !== 2'b11) begin
      n_err++; $display("FAIL mid_access: penable=%b busy=%b, want 1 1", m_penable, busy);
    end
    exp_req_q.delete();
    exp_rsp_q.delete();
    #2 preset_n = 1'b0;
    #1;
    act = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, rsp_valid, rsp_rdata,
           rsp_err, to_evt, busy, cmd_ready};
    n_cmp++;
    if (act !== {3'b000, 64'h0, 1'b0, 32'h0, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got %h, want %h", act, {3'b000, 64'h0, 1'b0, 32'h0, 3'b000, 1'b1});
    end
    @(negedge pclk); @(negedge pclk);
    preset_n = 1'b1;
    m_pready = 1'b1;
    saw_rsp = 1'b0; saw_sel = 1'b0; saw_busy = 1'b0;
    repeat (10) begin
      @(posedge pclk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
      if (m_psel) saw_sel = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_cmp++;
    if ({saw_rsp, saw_sel, saw_busy} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset: rsp_valid seen=%b psel seen=%b busy seen=%b, want 0 0 0",
               saw_rsp, saw_sel, saw_busy);
    end
    m_pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_err_hold();
`ifdef APB_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    n_cmp++;
    if (exp_req_q.size() + exp_rsp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d requests and %0d responses outstanding, want 0 and 0",
               exp_req_q.size(), exp_rsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 Parameter AW, 32, APB address width.
REQ-002 Parameter DW, 32, APB data width; PSTRB not used, all transfers are full-word.
REQ-003 Parameter DEPTH, 4, command FIFO depth; power of two, at least 2.
REQ-004 Parameter TO_CYC, 16, maximum ACCESS-phase cycles before timeout; at least 2.
REQ-005 pclk  in  1  clock; all logic rising-edge.
REQ-006 preset_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command push handshake.
REQ-008 cmd_write, cmd_addr, cmd_wdata  in  1, AW, DW  command fields (1 = write).
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-010 rsp_rdata, rsp_err  out  DW, 1  read data (0 for writes) and error flag.
REQ-011 m_psel, m_penable, m_pwrite, m_paddr, m_pwdata  out  1, 1, 1, AW, DW  APB master request.
REQ-012 m_pready, m_pslverr, m_prdata  in  1, 1, DW  APB completer response.
REQ-013 busy  out  1  high when FIFO non-empty or state is not IDLE.
REQ-014 to_evt  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 Push: cmd_valid and cmd_ready sampled high at an edge writes the command into the FIFO; cmd_ready = FIFO not full; no bypass; no push when full, even in a pop cycle.
REQ-016 FSM states: IDLE, SETUP, ACCESS; state is registered; m_psel = (SETUP or ACCESS); m_penable = ACCESS.
REQ-017 IDLE->SETUP when FIFO is non-empty and (rsp_valid is 0 or rsp_ready is 1); m_pwrite, m_paddr and m_pwdata load from the FIFO head on this edge and hold until the next load.
REQ-018 SETUP->ACCESS unconditionally after one cycle.
REQ-019 ACCESS with m_pready=1: FIFO pops; rsp_valid is set; rsp_err <= m_pslverr; rsp_rdata <= m_prdata for reads and 0 for writes; next state IDLE.
REQ-020 ACCESS with m_pready=0: remain in ACCESS, all m_* request outputs stable.
REQ-021 rsp_valid clears at an edge with rsp_ready=1 unless a new completion sets it on the same edge; rsp_rdata and rsp_err hold while rsp_valid=1 and rsp_ready=0.
REQ-022 Latency: command pushed at edge N on an idle block gives m_psel high after N+1, m_penable after N+2, and (zero-wait completer) rsp_valid after N+3; minimum 3 cycles per transfer when rsp_ready is held high.
REQ-023 Commands issue strictly in FIFO order; there is never more than one outstanding APB transfer.
REQ-024 A full FIFO with rsp_valid=1 and rsp_ready=0 stalls issue and push; there is no loss and no reordering.

Reset
REQ-025 On preset_n low, immediately: state IDLE, FIFO empty, m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, to_evt=0, busy=0, timeout counter 0; cmd_ready=1 (FIFO not full).
REQ-026 Reset mid-transfer drops the in-flight and queued commands; no response is produced for them.

Configuration
REQ-027 Macro APB_SEQ_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle with m_pready=0.
REQ-028 With the macro defined, m_pready=0 in the TO_CYC-th ACCESS cycle aborts the transfer at that edge: state goes to IDLE, FIFO pops, rsp_valid=1, rsp_err=1, rsp_rdata=0, to_evt pulses one cycle.
REQ-029 Macro not defined: no counter; ACCESS waits indefinitely; to_evt is tied 0.

Verification
REQ-030 Write 0x10/0xA5A5A5A5, zero-wait completer, rsp_ready=1 -> m_psel rises 1 cycle after push, m_penable 2 cycles after push, rsp_valid 3 cycles after push with rsp_err=0, rsp_rdata=0.
REQ-031 Push 5 commands back-to-back with the completer stalled -> cmd_ready=0 after the 4th push; the 5th is accepted after the first completion; the APB address order matches the push order.
REQ-032 Read 0x20, completer returns 0xDEADBEEF with m_pslverr=1 after 3 wait cycles, rsp_ready=0 for 5 cycles -> rsp_rdata=0xDEADBEEF and rsp_err=1 held; no new SETUP occurs until rsp_ready=1.
REQ-033 With APB_SEQ_TIMEOUT_EN, TO_CYC=16, m_pready held 0 -> exactly 16 ACCESS cycles, then to_evt=1 for 1 cycle, rsp_err=1, rsp_rdata=0; the next queued command then issues.
REQ-034 preset_n pulsed low during ACCESS with 3 commands queued -> all outputs reach their reset values asynchronously; no rsp_valid after release; busy=0.
